// File: rtl/q31_fp_pkg.sv
// Shared constants and pipeline-stage record types for the Q1.31 -> binary32 converter.
package q31_fp_pkg;

    localparam int Q_W       = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;
    localparam int LZ_W      = 6;

    localparam logic [Q_W-1:0] FP_POS_ZERO = 32'h0;

    // Stage 1: sign and unsigned magnitude of the sample.
    typedef struct packed {
        logic           sign;
        logic [Q_W-1:0] mag;
    } s1_t;

    // Stage 2: magnitude normalised so the leading one sits at bit 31.
    typedef struct packed {
        logic            sign;
        logic            zero;
        logic [LZ_W-1:0] lz;
        logic [Q_W-1:0]  norm;
    } s2_t;

    // Stage 3: rounded exponent and fraction, ready to pack.
    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } s3_t;

    function automatic logic [Q_W-1:0] pack_fp(input s3_t s);
        return s.zero ? FP_POS_ZERO : {s.sign, s.exp, s.frac};
    endfunction

endpackage

// File: rtl/lzd_32bit.sv
// Leading-zero detector: counts zeros above the most significant set bit (32 for all-zero).
module lzd_32bit (
    input  logic [31:0] data,
    output logic [5:0]  lz,
    output logic        zero
);

    // Priority scan from the LSB upward so the highest set bit wins the last assignment.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) lz = 6'(31 - i);
        end
        zero = (data == 32'd0);
    end

endmodule

// File: rtl/q31_to_fp32_pipe.sv
// Pipelined signed Q1.31 -> IEEE-754 binary32 converter, valid/ready on both sides,
// three register stages plus an output register, one sample per clock.
import q31_fp_pkg::*;

module q31_to_fp32_pipe #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_data
);

    logic en;
    logic s1_valid, s2_valid, s3_valid;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;

    logic [LZ_W-1:0] lzd_lz;
    logic            lzd_zero;

    // The whole pipe moves together; it only freezes when the output is held by the consumer.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: split the two's-complement sample into sign and magnitude (-1.0 gives 0x80000000).
    always_comb begin
        s1_d.sign = in_data[Q_W-1];
        s1_d.mag  = in_data[Q_W-1] ? (~in_data + 32'd1) : in_data;
    end

    lzd_32bit u_lzd (
        .data (s1_q.mag),
        .lz   (lzd_lz),
        .zero (lzd_zero)
    );

    // S2: shift the magnitude so its leading one lands at bit 31.
    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = lzd_zero;
        s2_d.lz   = lzd_lz;
        s2_d.norm = s1_q.mag << lzd_lz;
    end

    // S3: take 23 fraction bits below the hidden one, round, and fold any carry into the exponent.
    always_comb begin
        logic [FP_FRAC_W-1:0] frac;
        logic                 guard;
        logic                 sticky;
        logic                 up;
        logic [FP_FRAC_W:0]   frac_sum;
        logic [FP_EXP_W-1:0]  exp_base;

        frac     = s2_q.norm[30:8];
        guard    = s2_q.norm[7];
        sticky   = |s2_q.norm[6:0];
        up       = ROUND_EN && guard && (sticky || frac[0]);
        frac_sum = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, up};
        // Without a hidden one the sample is zero; the exponent is then irrelevant and held at 0.
        exp_base = s2_q.norm[31] ? (8'(FP_BIAS) - {2'b00, s2_q.lz}) : 8'd0;

        s3_d.sign = s2_q.sign;
        s3_d.zero = s2_q.zero;
        s3_d.exp  = exp_base + {7'd0, frac_sum[FP_FRAC_W]};
        s3_d.frac = frac_sum[FP_FRAC_W-1:0];
    end

    // Control: valid flags and the visible output, cleared on reset so in-flight samples vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP_POS_ZERO;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            out_data  <= pack_fp(s3_q);
        end
    end

    // Datapath: payload registers advance with the pipe and hold while it is frozen.
    always_ff @(posedge clk) begin
        // NOTE: payload flops carry no reset; the valid flags above decide whether their contents matter.
        if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_q31_to_fp32_pipe.sv
// Self-checking bench: directed vectors, latency, backpressure, mid-stream reset and random
// samples checked against a real-valued reference conversion through a scoreboard.
module tb_q31_to_fp32_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic        in_ready_t, out_valid_t;
    logic [31:0] out_data_t;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    logic [31:0] q_r[$];
    logic [31:0] q_t[$];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;

    always #5 clk = ~clk;

    q31_to_fp32_pipe #(.ROUND_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    q31_to_fp32_pipe #(.ROUND_EN(1'b0)) dut_trunc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .in_data   (in_data),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .out_data  (out_data_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact conversion to double, then round the 52-bit mantissa down to 23 bits.
    function automatic logic [31:0] ref_conv(input logic [31:0] d, input bit rne);
        real         r;
        logic [63:0] b;
        logic [22:0] f;
        logic [28:0] rest;
        logic [23:0] sum;
        bit          up;
        int          e8;
        if (d == 32'd0) return 32'd0;
        r    = real'($signed(d)) / 2147483648.0;
        b    = $realtobits(r);
        f    = b[51:29];
        rest = b[28:0];
        up   = rne && rest[28] && ((|rest[27:0]) || f[0]);
        sum  = {1'b0, f} + {23'd0, up};
        e8   = int'(b[62:52]) - 1023 + 127 + int'(sum[23]);
        return {b[63], 8'(e8), sum[22:0]};
    endfunction

    // Output monitor: compares at the falling edge, where every signal is settled.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            check("twin_handshake", {30'd0, in_ready_t, out_valid_t}, {30'd0, in_ready, out_valid});
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (q_r.size() == 0) begin
                    check("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("out_rne", out_data, q_r.pop_front());
                end
            end
            if (out_valid_t && out_ready) begin
                if (q_t.size() == 0) begin
                    check("unexpected_out_trunc", {31'd0, out_valid_t}, 32'd0);
                end else begin
                    check("out_trunc", out_data_t, q_t.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] e_r, input logic [31:0] e_t);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                q_r.push_back(e_r);
                q_t.push_back(e_t);
            end
            step();
        end
        if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && (q_r.size() != 0 || q_t.size() != 0); n++) step();
        check("drain_rne", q_r.size(), 32'd0);
        check("drain_trunc", q_t.size(), 32'd0);
    endtask

    logic [31:0] v_in[10];
    logic [31:0] v_rne[10];
    logic [31:0] v_trn[10];

    initial begin
        // {input, round-to-nearest-even, truncate}; the halfway point for 0.5-range samples is mag bit 6.
        v_in[0] = 32'h4000_0000; v_rne[0] = 32'h3F00_0000; v_trn[0] = 32'h3F00_0000;
        v_in[1] = 32'hC000_0000; v_rne[1] = 32'hBF00_0000; v_trn[1] = 32'hBF00_0000;
        v_in[2] = 32'h8000_0000; v_rne[2] = 32'hBF80_0000; v_trn[2] = 32'hBF80_0000;
        v_in[3] = 32'h0000_0000; v_rne[3] = 32'h0000_0000; v_trn[3] = 32'h0000_0000;
        v_in[4] = 32'hFFFF_FFFF; v_rne[4] = 32'hB000_0000; v_trn[4] = 32'hB000_0000;
        v_in[5] = 32'h7FFF_FFFF; v_rne[5] = 32'h3F80_0000; v_trn[5] = 32'h3F7F_FFFF;
        v_in[6] = 32'h0000_0001; v_rne[6] = 32'h3000_0000; v_trn[6] = 32'h3000_0000;
        v_in[7] = 32'h4000_0040; v_rne[7] = 32'h3F00_0000; v_trn[7] = 32'h3F00_0000;
        v_in[8] = 32'h4000_00C0; v_rne[8] = 32'h3F00_0002; v_trn[8] = 32'h3F00_0001;
        v_in[9] = 32'h4000_0180; v_rne[9] = 32'h3F00_0003; v_trn[9] = 32'h3F00_0003;

        // Reset state.
        #12;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: visible three edges after the accepting edge.
        send(32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000);
        step();
        step();
        check("latency_not_early", {31'd0, out_valid}, 32'd0);
        step();
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_data", out_data, 32'h3F00_0000);
        drain();

        // Directed vectors, back to back.
        for (int i = 0; i < 10; i++) send(v_in[i], v_rne[i], v_trn[i]);
        drain();

        // Backpressure: random consumer readiness while streaming.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d = $urandom;
            send(d, ref_conv(d, 1'b1), ref_conv(d, 1'b0));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        step();

        // Reset with samples in flight: everything is dropped.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d = $urandom;
            send(d, ref_conv(d, 1'b1), ref_conv(d, 1'b0));
        end
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_data", out_data, 32'd0);
        q_r.delete();
        q_t.delete();
        step();
        step();
        rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
                step();
            end
            check("no_stale_after_reset", {31'd0, seen}, 32'd0);
        end
        send(32'hC000_0000, 32'hBF00_0000, 32'hBF00_0000);
        drain();

        // Random samples against the reference, with many small magnitudes for deep normalisation.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] d = $urandom;
            if ($urandom_range(0, 1) == 1) d = $signed(d) >>> $urandom_range(0, 31);
            send(d, ref_conv(d, 1'b1), ref_conv(d, 1'b0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
